// File: rtl/sum_unit.sv
// Registered three-operand 4-bit adder with a saturating 10-bit running accumulator.
// Define SUM_INPUT_REG_EN to add an input register stage (2-cycle latency).
module sum_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] c,
    input  logic       in_valid,
    input  logic       acc_en,
    input  logic       acc_clr,
    output logic [5:0] out,
    output logic       out_valid,
    output logic [9:0] acc,
    output logic       acc_sat
);

    localparam logic [9:0] ACC_MAX = 10'd1023;

    logic [3:0] a_s;
    logic [3:0] b_s;
    logic [3:0] c_s;
    logic       in_valid_s;
    logic       acc_en_s;
    logic       acc_clr_s;
    logic [5:0] sum_s;
    logic [9:0] acc_next_s;
    logic       acc_sat_next_s;

    logic [5:0] out_r;
    logic       out_valid_r;
    logic [9:0] acc_r;
    logic       acc_sat_r;

    // Unclamped total carries into bit 10 exactly when it exceeds 1023.
    function automatic logic [10:0] acc_add(input logic [9:0] total, input logic [5:0] sample);
        acc_add = {1'b0, total} + {5'b00000, sample};
    endfunction

`ifdef SUM_INPUT_REG_EN
    logic [3:0] a_r;
    logic [3:0] b_r;
    logic [3:0] c_r;
    logic       in_valid_r;
    logic       acc_en_r;
    logic       acc_clr_r;

    // Input capture stage ahead of the adder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r        <= 4'd0;
            b_r        <= 4'd0;
            c_r        <= 4'd0;
            in_valid_r <= 1'b0;
            acc_en_r   <= 1'b0;
            acc_clr_r  <= 1'b0;
        end else begin
            a_r        <= a;
            b_r        <= b;
            c_r        <= c;
            in_valid_r <= in_valid;
            acc_en_r   <= acc_en;
            acc_clr_r  <= acc_clr;
        end
    end

    assign a_s        = a_r;
    assign b_s        = b_r;
    assign c_s        = c_r;
    assign in_valid_s = in_valid_r;
    assign acc_en_s   = acc_en_r;
    assign acc_clr_s  = acc_clr_r;
`else
    assign a_s        = a;
    assign b_s        = b;
    assign c_s        = c;
    assign in_valid_s = in_valid;
    assign acc_en_s   = acc_en;
    assign acc_clr_s  = acc_clr;
`endif

    assign sum_s = {2'b00, a_s} + {2'b00, b_s} + {2'b00, c_s};

    // Next accumulator state: clear wins over accumulate, saturate at 1023.
    always_comb begin
        logic [10:0] wide_s;
        wide_s         = acc_add(acc_r, sum_s);
        acc_next_s     = acc_r;
        acc_sat_next_s = acc_sat_r;
        if (acc_clr_s) begin
            acc_next_s     = 10'd0;
            acc_sat_next_s = 1'b0;
        end else if (in_valid_s && acc_en_s) begin
            if (wide_s[10]) begin
                acc_next_s     = ACC_MAX;
                acc_sat_next_s = 1'b1;
            end else begin
                acc_next_s     = wide_s[9:0];
                acc_sat_next_s = acc_sat_r;
            end
        end else begin
            acc_next_s     = acc_r;
            acc_sat_next_s = acc_sat_r;
        end
    end

    // Output and accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r       <= 6'd0;
            out_valid_r <= 1'b0;
            acc_r       <= 10'd0;
            acc_sat_r   <= 1'b0;
        end else begin
            if (in_valid_s) begin
                out_r <= sum_s;
            end else begin
                out_r <= out_r;
            end
            out_valid_r <= in_valid_s;
            acc_r       <= acc_next_s;
            acc_sat_r   <= acc_sat_next_s;
        end
    end

    assign out       = out_r;
    assign out_valid = out_valid_r;
    assign acc       = acc_r;
    assign acc_sat   = acc_sat_r;

endmodule

// File: tb/tb_sum_unit.sv
// Directed self-checking bench for sum_unit (default 1-cycle latency build).
module tb_sum_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] a, b, c;
    logic       in_valid, acc_en, acc_clr;
    logic [5:0] out;
    logic       out_valid;
    logic [9:0] acc;
    logic       acc_sat;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sum_unit dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c),
        .in_valid(in_valid), .acc_en(acc_en), .acc_clr(acc_clr),
        .out(out), .out_valid(out_valid), .acc(acc), .acc_sat(acc_sat)
    );

    // Apply inputs on the falling edge, return just after the next rising edge.
    task automatic drive(input logic [3:0] ta, input logic [3:0] tb_, input logic [3:0] tc,
                         input logic v, input logic en, input logic clr);
        @(negedge clk);
        a = ta; b = tb_; c = tc; in_valid = v; acc_en = en; acc_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15)); c = 4'($urandom_range(0, 15));
        in_valid = 1'b1; acc_en = 1'b1; acc_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out, out_valid, acc, acc_sat} !== 18'd0) begin
            failures++;
            $display("FAIL reset_hold: out=%0d ov=%0d acc=%0d sat=%0d, want all 0", out, out_valid, acc, acc_sat);
        end
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0; acc_en = 1'b0; a = 4'd7;
        @(posedge clk);
        #1;
        checks++;
        if ({out, out_valid, acc, acc_sat} !== 18'd0) begin
            failures++;
            $display("FAIL reset_release: out=%0d ov=%0d acc=%0d sat=%0d, want all 0", out, out_valid, acc, acc_sat);
        end
    endtask

    task automatic test_basic_sum;
        drive(4'd4, 4'd1, 4'd9, 1'b1, 1'b0, 1'b0);
        checks++;
        if (out !== 6'd14 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL sum_4_1_9: out=%0d ov=%0d, want 14 ov=1", out, out_valid);
        end
        drive(4'd15, 4'd15, 4'd15, 1'b1, 1'b0, 1'b0);
        checks++;
        if (out !== 6'd45 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL sum_max: out=%0d ov=%0d, want 45 ov=1", out, out_valid);
        end
        drive(4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (out !== 6'd0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL sum_zero: out=%0d ov=%0d, want 0 ov=1", out, out_valid);
        end
    endtask

    task automatic test_hold;
        drive(4'd3, 4'd3, 4'd3, 1'b1, 1'b0, 1'b0);
        checks++;
        if (out !== 6'd9 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL hold_load: out=%0d ov=%0d, want 9 ov=1", out, out_valid);
        end
        drive(4'd7, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (out !== 6'd9 || out_valid !== 1'b0 || acc !== 10'd0) begin
            failures++;
            $display("FAIL hold_idle: out=%0d ov=%0d acc=%0d, want 9 ov=0 acc=0", out, out_valid, acc);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 5; i++) begin
            logic [3:0] ra, rb, rc;
            int exp_sum;
            ra = 4'($urandom_range(0, 15)); rb = 4'($urandom_range(0, 15)); rc = 4'($urandom_range(0, 15));
            exp_sum = int'(ra) + int'(rb) + int'(rc);
            drive(ra, rb, rc, 1'b1, 1'b0, 1'b0);
            checks++;
            if (out !== exp_sum[5:0] || out_valid !== 1'b1 || acc !== 10'd0) begin
                failures++;
                $display("FAIL stream_%0d: out=%0d ov=%0d acc=%0d, want %0d ov=1 acc=0", i, out, out_valid, acc, exp_sum);
            end
        end
    endtask

    task automatic test_accumulate;
        for (int i = 0; i < 22; i++) drive(4'd15, 4'd15, 4'd15, 1'b1, 1'b1, 1'b0);
        checks++;
        if (acc !== 10'd990 || acc_sat !== 1'b0) begin
            failures++;
            $display("FAIL acc_22: acc=%0d sat=%0d, want 990 sat=0", acc, acc_sat);
        end
        drive(4'd15, 4'd15, 4'd15, 1'b1, 1'b1, 1'b0);
        checks++;
        if (acc !== 10'd1023 || acc_sat !== 1'b1) begin
            failures++;
            $display("FAIL acc_23_sat: acc=%0d sat=%0d, want 1023 sat=1", acc, acc_sat);
        end
        drive(4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (acc !== 10'd1023 || acc_sat !== 1'b1) begin
            failures++;
            $display("FAIL sat_sticky: acc=%0d sat=%0d, want 1023 sat=1", acc, acc_sat);
        end
    endtask

    task automatic test_clear_priority;
        drive(4'd15, 4'd15, 4'd15, 1'b1, 1'b1, 1'b1);
        checks++;
        if (acc !== 10'd0 || acc_sat !== 1'b0 || out !== 6'd45 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL clear_priority: acc=%0d sat=%0d out=%0d ov=%0d, want 0 0 45 1", acc, acc_sat, out, out_valid);
        end
    endtask

    task automatic test_boundary;
        for (int i = 0; i < 22; i++) drive(4'd15, 4'd15, 4'd15, 1'b1, 1'b1, 1'b0);
        drive(4'd15, 4'd15, 4'd3, 1'b1, 1'b1, 1'b0);
        checks++;
        if (acc !== 10'd1023 || acc_sat !== 1'b0 || out !== 6'd33) begin
            failures++;
            $display("FAIL exact_1023: acc=%0d sat=%0d out=%0d, want 1023 sat=0 out=33", acc, acc_sat, out);
        end
        drive(4'd1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (acc !== 10'd1023 || acc_sat !== 1'b0) begin
            failures++;
            $display("FAIL en_without_valid: acc=%0d sat=%0d, want 1023 sat=0", acc, acc_sat);
        end
        drive(4'd1, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (acc !== 10'd1023 || acc_sat !== 1'b1) begin
            failures++;
            $display("FAIL over_1024: acc=%0d sat=%0d, want 1023 sat=1", acc, acc_sat);
        end
    endtask

    task automatic test_midstream_reset;
        drive(4'd15, 4'd15, 4'd15, 1'b1, 1'b1, 1'b1);
        drive(4'd5, 4'd6, 4'd7, 1'b1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out, out_valid, acc, acc_sat} !== 18'd0) begin
            failures++;
            $display("FAIL async_reset: out=%0d ov=%0d acc=%0d sat=%0d, want all 0", out, out_valid, acc, acc_sat);
        end
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0; acc_en = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({out, out_valid, acc, acc_sat} !== 18'd0) begin
            failures++;
            $display("FAIL after_async_reset: out=%0d ov=%0d acc=%0d sat=%0d, want all 0", out, out_valid, acc, acc_sat);
        end
    endtask

    initial begin
        test_reset();
        test_basic_sum();
        test_hold();
        test_back_to_back();
        test_accumulate();
        test_clear_priority();
        test_boundary();
        drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (acc !== 10'd0 || acc_sat !== 1'b0) begin
            failures++;
            $display("FAIL clear_idle: acc=%0d sat=%0d, want 0 sat=0", acc, acc_sat);
        end
        test_midstream_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
